// File: rtl/toggle_event_rx.sv
// toggle_event_rx: receives a toggle-per-event line and drains its events through valid/ready
// Ports: clk; rst (async, active-low); tog_in (async toggle line); en (queue edges);
//        evt_ready/evt_valid (event handshake); clr_ovf (clear sticky ovf);
//        pending (queued events); total_cnt (all detected edges, wraps); ovf (event dropped
//        while full); tog_lvl (synchronised line level)
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int TOT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             en,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pending,
  output logic [TOT_W-1:0] total_cnt,
  output logic             ovf,
  output logic             tog_lvl
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [2:0]             prime_q, prime_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic [TOT_W-1:0]       total_q, total_d;
  logic                   ovf_q, ovf_d;
  logic                   primed, edge_det, queue_ev, take, full;
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], tog_in};
    primed    = prime_q == 3'd0;
    prime_d   = primed ? prime_q : prime_q - 3'd1;
    // While priming, prev follows the level the chain is about to present, so a line that was
    // already high at reset release lines up with prev before edge detection starts.
    prev_d    = primed ? sync_q[SYNC_STAGES-1] : sync_d[SYNC_STAGES-1];
    edge_det  = primed & (sync_q[SYNC_STAGES-1] ^ prev_q);
    queue_ev  = edge_det & en;
    take      = (pending_q != '0) & evt_ready;
    full      = &pending_q;
    pending_d = (queue_ev & !take) ? (full ? pending_q : pending_q + CNT_W'(1)) :
                (take & !queue_ev) ? pending_q - CNT_W'(1) : pending_q;
    ovf_d     = (queue_ev & !take & full) | (ovf_q & !clr_ovf);
    total_d   = total_q + TOT_W'(edge_det);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      prime_q   <= 3'(SYNC_STAGES);
      pending_q <= '0;
      total_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      prime_q   <= prime_d;
      pending_q <= pending_d;
      total_q   <= total_d;
      ovf_q     <= ovf_d;
    end
  end
  assign evt_valid = pending_q != '0;
  assign pending   = pending_q;
  assign total_cnt = total_q;
  assign ovf       = ovf_q;
  assign tog_lvl   = sync_q[SYNC_STAGES-1];
endmodule

// File: tb/tb_toggle_event_rx.sv
// tb_toggle_event_rx: directed checks of toggle_event_rx with hand-computed expectations
module tb_toggle_event_rx;
  logic        clk, rst, tog_in, en, evt_ready, clr_ovf;
  logic        evt_valid, ovf, tog_lvl;
  logic [3:0]  pending;
  logic [15:0] total_cnt;
  int n_vec = 0;
  int n_bad = 0;
  toggle_event_rx dut (
    .clk(clk), .rst(rst), .tog_in(tog_in), .en(en), .evt_ready(evt_ready), .clr_ovf(clr_ovf),
    .evt_valid(evt_valid), .pending(pending), .total_cnt(total_cnt), .ovf(ovf), .tog_lvl(tog_lvl)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic toggle3();
    tog_in = ~tog_in;
    tick(3);
  endtask
  initial begin
    rst = 1'b1; tog_in = 1'b1; en = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
    #1 rst = 1'b0;
    tick(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_lvl", tog_lvl, 0);
    rst = 1'b1;
    tick(10);
    chk("prime_valid", evt_valid, 0);
    chk("prime_total", total_cnt, 0);
    chk("prime_lvl", tog_lvl, 1);
    // single toggle: sampled at next posedge, pending rises two posedges later
    tog_in = ~tog_in;
    tick(2);
    chk("lat_early", evt_valid, 0);
    tick();
    chk("lat_valid", evt_valid, 1);
    chk("lat_pending", pending, 1);
    chk("lat_total", total_cnt, 1);
    evt_ready = 1'b1;
    tick();
    chk("take_pending", pending, 0);
    chk("take_valid", evt_valid, 0);
    tick(2);
    evt_ready = 1'b0;
    chk("empty_pending", pending, 0);
    // fill past capacity
    for (int i = 0; i < 16; i++) begin
      toggle3();
      if (i == 14) chk("full_no_ovf", ovf, 0);
    end
    chk("ovf_pending", pending, 15);
    chk("ovf_set", ovf, 1);
    chk("ovf_total", total_cnt, 17);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", ovf, 0);
    // edge lands in the same cycle as a take while full
    tog_in = ~tog_in;
    tick(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("full_take_pending", pending, 15);
    chk("full_take_ovf", ovf, 0);
    chk("full_take_total", total_cnt, 18);
    // dropped edge with clr_ovf in the same cycle: set wins
    tog_in = ~tog_in;
    tick(2);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("set_wins_ovf", ovf, 1);
    chk("set_wins_total", total_cnt, 19);
    evt_ready = 1'b1;
    clr_ovf = 1'b1;
    tick(15);
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    chk("drain_pending", pending, 0);
    chk("drain_ovf", ovf, 0);
    // disabled edges only reach total_cnt
    en = 1'b0;
    repeat (3) toggle3();
    en = 1'b1;
    tick(3);
    chk("dis_pending", pending, 0);
    chk("dis_total", total_cnt, 22);
    toggle3();
    chk("reen_pending", pending, 1);
    chk("reen_total", total_cnt, 23);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    repeat (5) toggle3();
    chk("pre_rst_pending", pending, 5);
    chk("pre_rst_total", total_cnt, 28);
    // asynchronous reset between clock edges
    #2 rst = 1'b0;
    #1;
    chk("arst_pending", pending, 0);
    chk("arst_total", total_cnt, 0);
    chk("arst_valid", evt_valid, 0);
    tick();
    rst = 1'b1;
    tick(10);
    chk("rerel_pending", pending, 0);
    chk("rerel_total", total_cnt, 0);
    chk("rerel_lvl", tog_lvl, tog_in);
    toggle3();
    chk("rerel_evt", pending, 1);
    chk("rerel_evt_total", total_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
